// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - two-channel debounced coin acceptor with inhibit-driven reject path
// Optional accepted-coin counters are compiled in when COIN_STATS_EN is defined.
module coin_acceptor #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin05_raw,
    input  logic       coin10_raw,
    input  logic       inhibit,
    output logic [1:0] coins,
    output logic [1:0] reject,
    output logic [7:0] cnt05,
    output logic [7:0] cnt10
);

    // Channel index 0 is the 0.5 coin, index 1 the 1.0 coin, so a one-hot
    // issue vector doubles as the output coin code.
    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    logic [1:0] raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] stable;
    logic [1:0] settle;
    logic [1:0] rise;
    logic [1:0] pend;
    logic [1:0] issue;
    logic [7:0] deb_cnt [2];

    assign raw = {coin10_raw, coin05_raw};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // settle: the differing level has now held for DEB_CYCLES cycles
    always_comb begin
        settle = '0;
        rise   = '0;
        for (int c = 0; c < 2; c++) begin
            settle[c] = (sync2[c] != stable[c]) && (deb_cnt[c] == DEB_LAST);
            rise[c]   = settle[c] && sync2[c];
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                stable[c]  <= 1'b0;
                deb_cnt[c] <= '0;
            end else if (sync2[c] == stable[c]) begin
                deb_cnt[c] <= '0;
            end else if (settle[c]) begin
                stable[c]  <= sync2[c];
                deb_cnt[c] <= '0;
            end else begin
                deb_cnt[c] <= deb_cnt[c] + 8'd1;
            end
        end
    end

    // 1.0 coin wins; the 0.5 coin stays pending for the next cycle.
    always_comb begin
        issue = 2'b00;
        if (pend[1]) begin
            issue = 2'b10;
        end else if (pend[0]) begin
            issue = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend   <= '0;
            coins  <= 2'b00;
            reject <= 2'b00;
        end else begin
            pend   <= (pend & ~issue) | rise;
            coins  <= inhibit ? 2'b00 : issue;
            reject <= inhibit ? issue : 2'b00;
        end
    end

`ifdef COIN_STATS_EN
    logic [7:0] cnt05_q;
    logic [7:0] cnt10_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt05_q <= '0;
            cnt10_q <= '0;
        end else begin
            if (!inhibit && issue[0] && (cnt05_q != 8'hFF)) begin
                cnt05_q <= cnt05_q + 8'd1;
            end
            if (!inhibit && issue[1] && (cnt10_q != 8'hFF)) begin
                cnt10_q <= cnt10_q + 8'd1;
            end
        end
    end

    assign cnt05 = cnt05_q;
    assign cnt10 = cnt10_q;
`else
    assign cnt05 = '0;
    assign cnt10 = '0;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - self-checking bench for coin_acceptor against a window-based reference model
module tb_coin_acceptor;

    localparam int DEB = 4;
`ifdef COIN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       coin05_raw;
    logic       coin10_raw;
    logic       inhibit;
    logic [1:0] coins;
    logic [1:0] reject;
    logic [7:0] cnt05;
    logic [7:0] cnt10;

    int n_cmp = 0;
    int n_bad = 0;

    coin_acceptor #(.DEB_CYCLES(DEB)) dut (
        .clk        (clk),
        .rst        (rst),
        .coin05_raw (coin05_raw),
        .coin10_raw (coin10_raw),
        .inhibit    (inhibit),
        .coins      (coins),
        .reject     (reject),
        .cnt05      (cnt05),
        .cnt10      (cnt10)
    );

    always #5 clk = ~clk;

    // Reference: a level is accepted once the last DEB synchronized samples
    // (raw delayed two edges) all disagree with the accepted level.
    bit         m_stable05, m_stable10, m_pend05, m_pend10;
    bit         h05[$];
    bit         h10[$];
    logic [1:0] m_coins  = 2'b00;
    logic [1:0] m_reject = 2'b00;
    int         m_cnt05  = 0;
    int         m_cnt10  = 0;

    always @(posedge clk) begin
        bit ev05, ev10, flip05, flip10;
        if (rst) begin
            h05.delete();
            h10.delete();
            for (int j = 0; j <= DEB; j++) begin
                h05.push_back(1'b0);
                h10.push_back(1'b0);
            end
            m_stable05 = 1'b0; m_stable10 = 1'b0;
            m_pend05   = 1'b0; m_pend10   = 1'b0;
            m_coins    = 2'b00; m_reject  = 2'b00;
            m_cnt05    = 0;     m_cnt10   = 0;
        end else begin
            flip05 = 1'b1;
            flip10 = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                if (h05[j] == m_stable05) flip05 = 1'b0;
                if (h10[j] == m_stable10) flip10 = 1'b0;
            end
            ev05 = flip05 && !m_stable05;
            ev10 = flip10 && !m_stable10;
            if (flip05) m_stable05 = !m_stable05;
            if (flip10) m_stable10 = !m_stable10;
            void'(h05.pop_front());
            void'(h10.pop_front());
            h05.push_back(coin05_raw);
            h10.push_back(coin10_raw);

            m_coins  = 2'b00;
            m_reject = 2'b00;
            if (m_pend10) begin
                if (inhibit) m_reject = 2'b10;
                else begin
                    m_coins = 2'b10;
                    if (m_cnt10 < 255) m_cnt10++;
                end
                m_pend10 = 1'b0;
            end else if (m_pend05) begin
                if (inhibit) m_reject = 2'b01;
                else begin
                    m_coins = 2'b01;
                    if (m_cnt05 < 255) m_cnt05++;
                end
                m_pend05 = 1'b0;
            end
            m_pend05 = m_pend05 | ev05;
            m_pend10 = m_pend10 | ev10;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("coins",  {6'b0, coins},  {6'b0, m_coins});
        chk("reject", {6'b0, reject}, {6'b0, m_reject});
        chk("cnt05",  cnt05, STATS ? 8'(m_cnt05) : 8'd0);
        chk("cnt10",  cnt10, STATS ? 8'(m_cnt10) : 8'd0);
        chk("exclusive", {7'b0, (coins != 2'b00) && (reject != 2'b00)}, 8'd0);
    endtask

    initial begin
        int         first;
        int         npulse;
        int         nrej;
        int         cnt10_before;
        logic [1:0] code;
        logic [1:0] seq [16];
        logic [1:0] rseq [16];

        rst = 1'b1; coin05_raw = 1'b0; coin10_raw = 1'b0; inhibit = 1'b0;
        tick();
        tick();
        chk("reset_coins",  {6'b0, coins},  8'd0);
        chk("reset_reject", {6'b0, reject}, 8'd0);
        rst = 1'b0;
        repeat (10) tick();

        // single 0.5 coin held 20 cycles
        coin05_raw = 1'b1; first = -1; npulse = 0; code = 2'b00;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (coins != 2'b00) begin
                npulse++;
                if (first < 0) begin first = i; code = coins; end
            end
        end
        coin05_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (coins != 2'b00) npulse++;
        end
        chk("r026_latency", 8'(first), 8'(DEB + 2));
        chk("r026_code",    {6'b0, code}, 8'd1);
        chk("r026_count",   8'(npulse), 8'd1);

        // 3-cycle glitch on 1.0 channel
        coin10_raw = 1'b1; npulse = 0;
        repeat (3) tick();
        coin10_raw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (coins != 2'b00 || reject != 2'b00) npulse++;
        end
        chk("r027_glitch", 8'(npulse), 8'd0);

        // simultaneous insertion
        coin05_raw = 1'b1; coin10_raw = 1'b1; npulse = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seq[i] = coins;
            if (coins != 2'b00) npulse++;
        end
        coin05_raw = 1'b0; coin10_raw = 1'b0;
        repeat (12) tick();
        chk("r028_first",  {6'b0, seq[DEB + 2]}, 8'd2);
        chk("r028_second", {6'b0, seq[DEB + 3]}, 8'd1);
        chk("r028_after",  {6'b0, seq[DEB + 4]}, 8'd0);
        chk("r028_count",  8'(npulse), 8'd2);

        // inhibited 1.0 coin
        cnt10_before = m_cnt10;
        inhibit = 1'b1; coin10_raw = 1'b1; npulse = 0; nrej = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            rseq[i] = reject;
            if (coins != 2'b00) npulse++;
            if (reject != 2'b00) nrej++;
        end
        coin10_raw = 1'b0;
        repeat (12) tick();
        inhibit = 1'b0;
        chk("r029_reject", {6'b0, rseq[DEB + 2]}, 8'd2);
        chk("r029_rcount", 8'(nrej), 8'd1);
        chk("r029_coins",  8'(npulse), 8'd0);
        chk("r029_cnt10",  cnt10, STATS ? 8'(cnt10_before) : 8'd0);

        // reset while a coin is mid-debounce, sensor still held afterwards
        coin05_raw = 1'b1;
        repeat (DEB) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (15) tick();
        coin05_raw = 1'b0;
        repeat (10) tick();

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 5) == 0) coin05_raw = ~coin05_raw;
            if ($urandom_range(0, 6) == 0) coin10_raw = ~coin10_raw;
            inhibit = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst = 1'b1; coin05_raw = 1'b0; coin10_raw = 1'b0; inhibit = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // 257 separate 0.5 coins: counter saturates
        for (int k = 0; k < 257; k++) begin
            coin05_raw = 1'b1;
            repeat (DEB + 4) tick();
            coin05_raw = 1'b0;
            repeat (DEB + 4) tick();
        end
        chk("r030_sat", cnt05, STATS ? 8'd255 : 8'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r030_rst_cnt05",  cnt05, 8'd0);
        chk("r030_rst_coins",  {6'b0, coins}, 8'd0);
        chk("r030_rst_reject", {6'b0, reject}, 8'd0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
